// File: rtl/immgen_pipe_pkg.sv
// Shared constants for the immediate generator pipeline: format select
// codes, base opcodes and the opcode-driven format resolver used by AUTO mode.
package immgen_pipe_pkg;

  // Format select / resolved format codes. I..J keep their historical values;
  // Z, SH and AUTO occupy the three codes that used to be free.
  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_Z    = 3'd5;
  localparam logic [2:0] IMM_SH   = 3'd6;
  localparam logic [2:0] IMM_AUTO = 3'd7;

  // Major opcodes (inst[6:0]) that carry an immediate.
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Result of opcode-based format resolution.
  typedef struct packed {
    logic [2:0] fmt;
    logic       illegal;
  } fmt_res_t;

  // funct3 001 (sll*) and 101 (srl*/sra*) are the shift-immediate encodings.
  function automatic logic is_shift_f3(input logic [2:0] funct3);
    return funct3[1:0] == 2'b01;
  endfunction

  // Derive the immediate format from the opcode. Unknown opcodes report
  // illegal with fmt left at I so downstream never sees the AUTO code.
  function automatic fmt_res_t auto_decode(input logic [6:0] opcode,
                                           input logic [2:0] funct3);
    fmt_res_t r;
    r.fmt     = IMM_I;
    r.illegal = 1'b0;
    case (opcode)
      OP_IMM, OP_IMM32: r.fmt = is_shift_f3(funct3) ? IMM_SH : IMM_I;
      OP_LOAD, OP_JALR: r.fmt = IMM_I;
      OP_STORE:         r.fmt = IMM_S;
      OP_BRANCH:        r.fmt = IMM_B;
      OP_LUI, OP_AUIPC: r.fmt = IMM_U;
      OP_JAL:           r.fmt = IMM_J;
      OP_SYSTEM:        r.fmt = funct3[2] ? IMM_Z : IMM_I;
      default:          r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/immgen_pipe_imm_fifo.sv
// Generic DEPTH x W in-order buffer with valid/ready on both sides.
// Ready is derived only from the registered occupancy, so there is no
// combinational path from the consumer's ready back to the producer.
// Head data reads as zero while empty. Flush and reset both empty it.
module imm_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Storage write; a word presented alongside flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers and occupancy; flush overrides any simultaneous push or pop.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator. Each accepted instruction word has its
// format resolved (explicit select or opcode-driven AUTO), its immediate
// extracted and extended to XLEN, and the result queued with its tag.
import immgen_pipe_pkg::*;

module immgen_pipe #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter int TAGW  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [2:0]      in_immsel,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [TAGW-1:0] out_tag
);

  localparam int W = TAGW + 1 + 3 + XLEN;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            shamt5;
  fmt_res_t        auto_res;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_z;
  logic [XLEN-1:0] imm_sh;

  logic [2:0]      res_fmt;
  logic            res_illegal;
  logic [XLEN-1:0] res_imm;

  logic [W-1:0]    push_data;
  logic [W-1:0]    head_data;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign auto_res = auto_decode(opcode, funct3);

  // W-ops only ever shift by up to 31, as does everything on a 32-bit core.
  assign shamt5 = (XLEN == 32) || (opcode == OP_IMM32);

  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                 in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                 in_inst[30:21], 1'b0}));
  assign imm_z  = XLEN'(in_inst[19:15]);
  assign imm_sh = shamt5 ? XLEN'(in_inst[24:20]) : XLEN'(in_inst[25:20]);

  // Resolve the format, pick the matching immediate, zero it when illegal.
  always_comb begin
    res_fmt     = IMM_I;
    res_illegal = 1'b0;
    res_imm     = '0;

    if (in_immsel == IMM_AUTO) begin
      res_fmt     = auto_res.fmt;
      res_illegal = auto_res.illegal;
    end else begin
      res_fmt = in_immsel;
    end

    case (res_fmt)
      IMM_I:  res_imm = imm_i;
      IMM_S:  res_imm = imm_s;
      IMM_B:  res_imm = imm_b;
      IMM_U:  res_imm = imm_u;
      IMM_J:  res_imm = imm_j;
      IMM_Z:  res_imm = imm_z;
      IMM_SH: begin
        res_imm = imm_sh;
        if (shamt5 && in_inst[25]) begin
          res_illegal = 1'b1;
        end
      end
      default: begin
        res_fmt     = IMM_I;
        res_illegal = 1'b1;
      end
    endcase

    if (res_illegal) begin
      res_imm = '0;
    end
  end

  assign push_data = {in_tag, res_illegal, res_fmt, res_imm};

  imm_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_data)
  );

  assign {out_tag, out_illegal, out_fmt, out_imm} = head_data;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: a 64-bit and a 32-bit instance share one input
// stream; directed scenarios plus a randomized run against a queue model.
module tb_immgen_pipe;

  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3,
                         F_J = 3'd4, F_Z = 3'd5, F_SH = 3'd6, F_AUTO = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [2:0]  in_immsel;
  logic [63:0] in_tag;

  logic        rdy64, val64, ill64, rdy32, val32, ill32;
  logic [63:0] imm64, tag64, tag32;
  logic [31:0] imm32;
  logic [2:0]  fmt64, fmt32;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [2:0]  fmt;
    logic        ill64;
    logic        ill32;
    logic [63:0] tag;
  } exp_t;

  exp_t q[$];

  immgen_pipe #(.XLEN(64), .DEPTH(2), .TAGW(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_inst(in_inst), .in_immsel(in_immsel), .in_tag(in_tag), .out_valid(val64),
    .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64),
    .out_tag(tag64));

  immgen_pipe #(.XLEN(32), .DEPTH(2), .TAGW(64)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_inst(in_inst), .in_immsel(in_immsel), .in_tag(in_tag), .out_valid(val32),
    .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32),
    .out_tag(tag32));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sext(input longint x, input int n);
    longint m;
    m = (longint'(1) << n) - 1;
    x = x & m;
    if (((x >> (n - 1)) & 1) != 0) x = x - (longint'(1) << n);
    return x;
  endfunction

  // Reference: resolve format from the rules, then rebuild the immediate
  // as an integer value from its fields.
  function automatic void ref_imm(input logic [31:0] inst, input logic [2:0] sel,
                                  input int xlen, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    int unsigned op, f3;
    longint v;
    logic [63:0] u;
    bit sh5;
    op  = inst & 32'h7F;
    f3  = (inst >> 12) & 7;
    ill = 1'b0;
    fmt = sel;
    v   = 0;
    if (sel == F_AUTO) begin
      case (op)
        'h13, 'h1B: fmt = (f3 == 1 || f3 == 5) ? F_SH : F_I;
        'h03, 'h67: fmt = F_I;
        'h23:       fmt = F_S;
        'h63:       fmt = F_B;
        'h37, 'h17: fmt = F_U;
        'h6F:       fmt = F_J;
        'h73:       fmt = (f3 >= 4) ? F_Z : F_I;
        default:    begin fmt = F_I; ill = 1'b1; end
      endcase
    end
    case (fmt)
      F_I: v = sext(inst >> 20, 12);
      F_S: v = sext(((inst >> 25) << 5) | ((inst >> 7) & 31), 12);
      F_B: v = sext(((inst >> 31) << 12) | (((inst >> 7) & 1) << 11) |
                    (((inst >> 25) & 63) << 5) | (((inst >> 8) & 15) << 1), 13);
      F_U: v = sext(inst & 32'hFFFFF000, 32);
      F_J: v = sext(((inst >> 31) << 20) | (((inst >> 12) & 255) << 12) |
                    (((inst >> 20) & 1) << 11) | (((inst >> 21) & 1023) << 1), 21);
      F_Z: v = (inst >> 15) & 31;
      F_SH: begin
        sh5 = (xlen == 32) || (op == 'h1B);
        v = sh5 ? ((inst >> 20) & 31) : ((inst >> 20) & 63);
        if (sh5 && ((inst >> 25) & 1) != 0) ill = 1'b1;
      end
      default: begin fmt = F_I; ill = 1'b1; end
    endcase
    if (ill) v = 0;
    u = v;
    if (xlen == 32) u = u & 64'h0000_0000_FFFF_FFFF;
    imm = u;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_immsel = F_I; in_tag = '0;
    tick(); tick();
    rst_n = 1'b1;
    checks++; if ({val64, rdy64, val32, rdy32} !== 4'b0101) begin errors++; $display("FAIL reset_hs got %b exp 0101", {val64, rdy64, val32, rdy32}); end
    checks++; if ({imm64, tag64, fmt64, ill64} !== '0) begin errors++; $display("FAIL reset_out64 got imm %h tag %h fmt %0d ill %0b exp all 0", imm64, tag64, fmt64, ill64); end
    checks++; if ({imm32, tag32, fmt32, ill32} !== '0) begin errors++; $display("FAIL reset_out32 got imm %h tag %h fmt %0d ill %0b exp all 0", imm32, tag32, fmt32, ill32); end
  endtask

  task automatic test_i_format();
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_immsel = F_I; in_tag = 64'h1000;
    checks++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL i_ready got %0b exp 1", rdy64); end
    tick();
    in_valid = 1'b0;
    checks++; if ({val64, ill64} !== 2'b10) begin errors++; $display("FAIL i_valid_ill got %b exp 10", {val64, ill64}); end
    checks++; if (imm64 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL i_imm64 got %h exp ffffffffffffffff", imm64); end
    checks++; if (imm32 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL i_imm32 got %h exp ffffffff", imm32); end
    checks++; if ({tag64, fmt64} !== {64'h1000, F_I}) begin errors++; $display("FAIL i_tag_fmt got %h/%0d exp 1000/0", tag64, fmt64); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if ({val64, imm64} !== '0) begin errors++; $display("FAIL i_drain got valid %0b imm %h exp 0/0", val64, imm64); end
  endtask

  task automatic test_auto_jz();
    in_valid = 1'b1; in_inst = 32'h0040006F; in_immsel = F_AUTO; in_tag = 64'h2;
    tick();
    checks++; if ({imm64, fmt64, ill64} !== {64'd4, F_J, 1'b0}) begin errors++; $display("FAIL auto_jal got imm %0d fmt %0d ill %0b exp 4/4/0", imm64, fmt64, ill64); end
    in_inst = 32'h300FD073; in_tag = 64'h3; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if ({imm64, fmt64, ill64, tag64} !== {64'd31, F_Z, 1'b0, 64'h3}) begin errors++; $display("FAIL auto_csr got imm %0d fmt %0d ill %0b tag %h exp 31/5/0/3", imm64, fmt64, ill64, tag64); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_auto_illegal();
    in_valid = 1'b1; in_inst = 32'h02009093; in_immsel = F_AUTO; in_tag = 64'h4;
    tick();
    checks++; if ({ill32, fmt32} !== {1'b1, F_SH}) begin errors++; $display("FAIL shamt32_ill got ill %0b fmt %0d exp 1/6", ill32, fmt32); end
    checks++; if ({ill64, imm64} !== {1'b0, 64'd32}) begin errors++; $display("FAIL shamt64 got ill %0b imm %0d exp 0/32", ill64, imm64); end
    in_inst = 32'h0000007F; in_tag = 64'h5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if ({ill64, imm64, fmt64} !== {1'b1, 64'd0, F_I}) begin errors++; $display("FAIL badop64 got ill %0b imm %h fmt %0d exp 1/0/0", ill64, imm64, fmt64); end
    checks++; if ({ill32, imm32, tag32} !== {1'b1, 32'd0, 64'h5}) begin errors++; $display("FAIL badop32 got ill %0b imm %h tag %h exp 1/0/5", ill32, imm32, tag32); end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00100093; in_immsel = F_I;
    in_tag = 64'd1;
    tick();
    in_tag = 64'd2;
    checks++; if (rdy64 !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b exp 1", rdy64); end
    tick();
    in_tag = 64'd3;
    checks++; if ({rdy64, rdy32} !== 2'b00) begin errors++; $display("FAIL b2b_full got %b exp 00", {rdy64, rdy32}); end
    tick();
    checks++; if ({rdy64, tag64} !== {1'b0, 64'd1}) begin errors++; $display("FAIL b2b_held got rdy %0b tag %0d exp 0/1", rdy64, tag64); end
    out_ready = 1'b1;
    tick();
    checks++; if ({rdy64, tag64} !== {1'b1, 64'd2}) begin errors++; $display("FAIL b2b_pop1 got rdy %0b tag %0d exp 1/2", rdy64, tag64); end
    tick();
    checks++; if ({val64, tag64} !== {1'b1, 64'd3}) begin errors++; $display("FAIL b2b_pop2 got val %0b tag %0d exp 1/3", val64, tag64); end
    out_ready = 1'b0; in_tag = 64'd4;
    tick();
    out_ready = 1'b1; in_tag = 64'd5;
    checks++; if ({rdy64, tag64} !== {1'b0, 64'd3}) begin errors++; $display("FAIL b2b_full2 got rdy %0b tag %0d exp 0/3", rdy64, tag64); end
    tick();
    checks++; if ({rdy64, tag64} !== {1'b1, 64'd4}) begin errors++; $display("FAIL b2b_poponly got rdy %0b tag %0d exp 1/4", rdy64, tag64); end
    tick();
    in_valid = 1'b0;
    checks++; if ({val64, rdy64, tag64} !== {2'b11, 64'd5}) begin errors++; $display("FAIL b2b_stream got val %0b rdy %0b tag %0d exp 1/1/5", val64, rdy64, tag64); end
    tick();
    out_ready = 1'b0;
    checks++; if (val64 !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", val64); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_immsel = F_I; in_inst = 32'h00200093;
    in_tag = 64'd10; tick();
    in_tag = 64'd11; tick();
    checks++; if ({val64, rdy64} !== 2'b10) begin errors++; $display("FAIL flush_pre got %b exp 10", {val64, rdy64}); end
    flush = 1'b1; in_tag = 64'd12; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if ({val64, rdy64, tag64, val32, rdy32} !== {2'b01, 64'd0, 2'b01}) begin errors++; $display("FAIL flush_full got val %0b rdy %0b tag %0d exp 0/1/0", val64, rdy64, tag64); end
    tick();
    checks++; if (val64 !== 1'b0) begin errors++; $display("FAIL flush_ghost got val %0b tag %0d exp 0", val64, tag64); end
    out_ready = 1'b0; in_valid = 1'b1; in_tag = 64'd13;
    tick();
    flush = 1'b1; in_tag = 64'd14;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if ({val64, rdy64} !== 2'b01) begin errors++; $display("FAIL flush_push got val %0b rdy %0b tag %0d exp 0/1", val64, rdy64, tag64); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_immsel = F_U; in_inst = 32'h80000037;
    in_tag = 64'd20; tick();
    in_tag = 64'd21; tick();
    rst_n = 1'b0; in_tag = 64'd22;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    checks++; if ({val64, rdy64, imm64, tag64, fmt64, ill64} !== {2'b01, 64'd0, 64'd0, 3'd0, 1'b0}) begin errors++; $display("FAIL rst_mid got val %0b rdy %0b imm %h tag %h fmt %0d ill %0b", val64, rdy64, imm64, tag64, fmt64, ill64); end
    in_valid = 1'b1; in_tag = 64'd23;
    tick();
    in_valid = 1'b0;
    checks++; if ({val64, tag64, imm64, imm32} !== {1'b1, 64'd23, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000}) begin errors++; $display("FAIL rst_push got val %0b tag %0d imm %h/%h exp 1/23/ffffffff80000000/80000000", val64, tag64, imm64, imm32); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [6:0] opc [10] = '{7'h13, 7'h1B, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73};
    exp_t e, h;
    logic [63:0] t64;
    logic [2:0]  f32;
    logic        exp_rdy, exp_val, do_push, do_pop;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    q.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_rdy = (q.size() < 2);
      exp_val = (q.size() != 0);
      checks++; if ({rdy64, val64, rdy32, val32} !== {exp_rdy, exp_val, exp_rdy, exp_val}) begin errors++; $display("FAIL rnd_hs cyc %0d got %b exp %b", cyc, {rdy64, val64, rdy32, val32}, {exp_rdy, exp_val, exp_rdy, exp_val}); end
      h = '{imm64: '0, imm32: '0, fmt: '0, ill64: 1'b0, ill32: 1'b0, tag: '0};
      if (exp_val) h = q[0];
      checks++; if ({imm64, fmt64, ill64, tag64} !== {h.imm64, h.fmt, h.ill64, h.tag}) begin errors++; $display("FAIL rnd_head64 cyc %0d got %h/%0d/%0b/%h exp %h/%0d/%0b/%h", cyc, imm64, fmt64, ill64, tag64, h.imm64, h.fmt, h.ill64, h.tag); end
      checks++; if ({imm32, fmt32, ill32, tag32} !== {h.imm32, h.fmt, h.ill32, h.tag}) begin errors++; $display("FAIL rnd_head32 cyc %0d got %h/%0d/%0b/%h exp %h/%0d/%0b/%h", cyc, imm32, fmt32, ill32, tag32, h.imm32, h.fmt, h.ill32, h.tag); end

      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      in_inst   = $urandom();
      if ($urandom_range(0, 9) < 8) in_inst[6:0] = opc[$urandom_range(0, 9)];
      in_immsel = 3'($urandom_range(0, 7));
      in_tag    = {$urandom(), $urandom()};

      do_push = in_valid && exp_rdy;
      do_pop  = exp_val && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          ref_imm(in_inst, in_immsel, 64, e.imm64, e.fmt, e.ill64);
          ref_imm(in_inst, in_immsel, 32, t64, f32, e.ill32);
          e.imm32 = t64[31:0];
          e.tag   = in_tag;
          q.push_back(e);
        end
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_auto_jz();
    test_auto_illegal();
    test_back_to_back();
    test_flush();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
